// File: rtl/mem_sys_pkg.sv
// Shared types and defaults for the memory fill front end: FSM state
// encoding, default widths and a constant-time log2 helper.
package mem_sys_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_ADDR_W         = 16;
  localparam int DEF_DATA_W         = 16;
  localparam int DEF_WORDS          = 8;
  localparam int DEF_BYTES_PER_WORD = 2;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// Pipelined memory bus between the fill engine (master) and the
// fixed-latency main memory (slave).
interface mem_fill_arbiter_if
  import mem_sys_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/mem_fill_arb.sv
// Miss channel selector: one-hot pick among pending misses.
// Default build: fixed priority, channel 0 highest.
// With MEM_FILL_ARB_RR_EN defined: round-robin, the search starts at the
// channel after the one whose fill most recently completed.
module mem_fill_arb
  import mem_sys_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
`ifdef MEM_FILL_ARB_RR_EN
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic [NUM_CH-1:0] done_ch,
`endif
  input  logic [NUM_CH-1:0] miss_req,
  output logic [NUM_CH-1:0] sel
);

`ifdef MEM_FILL_ARB_RR_EN
  localparam int PTR_W = (NUM_CH > 1) ? clog2_f(NUM_CH) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic             found;

  // Two-pass search: channels at or above the pointer first, then wrap.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && miss_req[i] && (PTR_W'(i) >= ptr_q)) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && miss_req[i]) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // Next pointer is the channel after the one just completed.
  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (done_ch[i]) ptr_d = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  // Pointer register, moved only when a fill finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr_q <= '0;
    else if (advance) ptr_q <= ptr_d;
  end
`else
  // Isolate the lowest set request bit.
  assign sel = miss_req & (~miss_req + NUM_CH'(1));
`endif

endmodule

// File: rtl/mem_fill_arbiter.sv
// Cache block fill engine shared by NUM_CH miss channels and one
// write-through port over a single fixed-latency pipelined memory.
// Writes win over misses so a following fill sees the written data.
// Optional: MEM_FILL_ARB_RR_EN selects round-robin miss arbitration.
module mem_fill_arbiter
  import mem_sys_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int WORDS          = DEF_WORDS,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        miss_req,
  input  logic [NUM_CH*ADDR_W-1:0] miss_addr,
  output logic [NUM_CH-1:0]        grant,
  output logic [NUM_CH-1:0]        fill_we,
  output logic [NUM_CH-1:0]        tag_we,
  output logic [NUM_CH-1:0]        fill_done,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [DATA_W-1:0]        fill_data,
  output logic                     busy,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  mem_fill_arbiter_if.master       mem
);

  localparam int CNT_W = clog2_f(WORDS) + 1;
  localparam int OFF_W = clog2_f(WORDS * BYTES_PER_WORD);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [ADDR_W-1:0] BPW_A    = ADDR_W'(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0]  WORDS_C  = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(WORDS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issue_q, issue_d;
  logic [CNT_W-1:0]  recv_q,  recv_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic [NUM_CH-1:0] arb_sel;
  logic [ADDR_W-1:0] sel_addr;

`ifdef MEM_FILL_ARB_RR_EN
  logic fill_done_any;
  assign fill_done_any = |fill_done;

  mem_fill_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (fill_done_any),
    .done_ch  (grant_q),
    .miss_req (miss_req),
    .sel      (arb_sel)
  );
`else
  mem_fill_arb #(.NUM_CH(NUM_CH)) u_arb (
    .miss_req (miss_req),
    .sel      (arb_sel)
  );
`endif

  // Miss address of the arbitration winner.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_sel[i]) sel_addr = miss_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Control state: FSM, counters and registered grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      issue_q <= '0;
      recv_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      grant_q <= grant_d;
    end
  end

  // Block base address; only meaningful while a fill is in progress.
  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

  // Next state plus all memory-side and cache-side strobes.
  always_comb begin
    state_d        = state_q;
    issue_d        = issue_q;
    recv_d         = recv_q;
    grant_d        = grant_q;
    base_d         = base_q;
    fill_we        = '0;
    tag_we         = '0;
    fill_done      = '0;
    fill_addr      = '0;
    fill_data      = '0;
    wr_ack         = 1'b0;
    mem.mem_en     = 1'b0;
    mem.mem_wr     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = WR;
        end else if (|arb_sel) begin
          state_d = FILL;
          grant_d = arb_sel;
          base_d  = sel_addr & ~OFF_MASK;
          issue_d = '0;
          recv_d  = '0;
        end
      end

      WR: begin
        mem.mem_en    = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = wr_addr;
        mem.mem_wdata = wr_data;
        wr_ack        = 1'b1;
        state_d       = IDLE;
      end

      FILL: begin
        if (issue_q < WORDS_C) begin
          mem.mem_en   = 1'b1;
          mem.mem_addr = base_q + ADDR_W'(issue_q) * BPW_A;
          issue_d      = issue_q + CNT_W'(1);
        end
        if (mem.mem_rvalid) begin
          fill_we   = grant_q;
          fill_addr = base_q + ADDR_W'(recv_q) * BPW_A;
          fill_data = mem.mem_rdata;
          recv_d    = recv_q + CNT_W'(1);
          if (recv_q == LAST_C) begin
            tag_we    = grant_q;
            fill_done = grant_q;
            grant_d   = '0;
            state_d   = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency memory model.
// Memory word at byte address a holds a ^ 16'hA5A5 unless written.
module tb_mem_fill_arbiter;
  import mem_sys_pkg::*;

  localparam int LAT   = 4;
  localparam int WORDS = 8;

  logic        clk;
  logic        rst_n;
  logic [1:0]  miss_req;
  logic [31:0] miss_addr;
  logic [1:0]  grant, fill_we, tag_we, fill_done;
  logic [15:0] fill_addr, fill_data;
  logic        busy;
  logic        wr_req;
  logic [15:0] wr_addr, wr_data;
  logic        wr_ack;
  logic        stray;

  int n_chk;
  int n_pass;

  logic [15:0] shadow [logic [15:0]];

  mem_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16)) mif ();

  mem_fill_arbiter #(
    .NUM_CH(2), .ADDR_W(16), .DATA_W(16), .WORDS(WORDS), .BYTES_PER_WORD(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .grant(grant), .fill_we(fill_we), .tag_we(tag_we), .fill_done(fill_done),
    .fill_addr(fill_addr), .fill_data(fill_data), .busy(busy),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem(mif)
  );

  // Memory model: word array plus LAT-deep read pipeline.
  logic [15:0]    mem_arr [0:32767];
  logic [LAT-1:0] pv;
  logic [15:0]    pd [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv <= '0;
    else        pv <= {pv[LAT-2:0], mif.mem_en & ~mif.mem_wr};
  end

  always_ff @(posedge clk) begin
    pd[0] <= mem_arr[mif.mem_addr[15:1]];
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    if (mif.mem_en && mif.mem_wr) mem_arr[mif.mem_addr[15:1]] <= mif.mem_wdata;
  end

  assign mif.mem_rvalid = pv[LAT-1] | stray;
  assign mif.mem_rdata  = pv[LAT-1] ? pd[LAT-1] : 16'h7777;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    if (shadow.exists(a)) return shadow[a];
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, " grant"},     grant, 0);
    chk({tag, " fill_we"},   fill_we, 0);
    chk({tag, " tag_we"},    tag_we, 0);
    chk({tag, " fill_done"}, fill_done, 0);
    chk({tag, " fill_addr"}, fill_addr, 0);
    chk({tag, " fill_data"}, fill_data, 0);
    chk({tag, " busy"},      busy, 0);
    chk({tag, " wr_ack"},    wr_ack, 0);
    chk({tag, " mem_en"},    mif.mem_en, 0);
    chk({tag, " mem_wr"},    mif.mem_wr, 0);
    chk({tag, " mem_addr"},  mif.mem_addr, 0);
    chk({tag, " mem_wdata"}, mif.mem_wdata, 0);
  endtask

  // Called in IDLE with miss_req[ch] already raised; returns in the IDLE
  // cycle after DONE. k counts cycles from the first FILL cycle.
  task automatic run_fill(input int ch, input logic [15:0] maddr,
                          input int drop_at, input int wr_at);
    logic [15:0] base;
    logic [15:0] ea;
    logic [1:0]  g;
    string       t;
    base = maddr & 16'hFFF0;
    g    = 2'(1 << ch);
    for (int k = 0; k <= WORDS + LAT + 1; k++) begin
      step();
      t = $sformatf("ch%0d@%h k%0d", ch, maddr, k);
      chk({t, " wr_ack"}, wr_ack, 0);
      if (k < WORDS + LAT) begin
        chk({t, " grant"}, grant, g);
        chk({t, " busy"},  busy, 1);
        chk({t, " mem_en"}, mif.mem_en, (k < WORDS) ? 1 : 0);
        chk({t, " mem_wr"}, mif.mem_wr, 0);
        if (k < WORDS) chk({t, " mem_addr"}, mif.mem_addr, base + 16'(2 * k));
        if (k >= LAT) begin
          ea = base + 16'(2 * (k - LAT));
          chk({t, " fill_we"},   fill_we, g);
          chk({t, " fill_addr"}, fill_addr, ea);
          chk({t, " fill_data"}, fill_data, exp_word(ea));
        end else begin
          chk({t, " fill_we"}, fill_we, 0);
        end
        chk({t, " tag_we"},    tag_we,    (k == WORDS + LAT - 1) ? g : 2'b00);
        chk({t, " fill_done"}, fill_done, (k == WORDS + LAT - 1) ? g : 2'b00);
      end else if (k == WORDS + LAT) begin
        chk({t, " done grant"},  grant, 0);
        chk({t, " done busy"},   busy, 1);
        chk({t, " done mem_en"}, mif.mem_en, 0);
        chk({t, " done tag_we"}, tag_we, 0);
      end else begin
        chk({t, " idle busy"},  busy, 0);
        chk({t, " idle grant"}, grant, 0);
      end
      if (k == drop_at) miss_req[ch] = 1'b0;
      if (k == wr_at)   wr_req = 1'b1;
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    chk("wr ack",   wr_ack, 1);
    chk("wr en",    mif.mem_en, 1);
    chk("wr wr",    mif.mem_wr, 1);
    chk("wr addr",  mif.mem_addr, a);
    chk("wr wdata", mif.mem_wdata, d);
    chk("wr grant", grant, 0);
    chk("wr busy",  busy, 1);
    wr_req    = 1'b0;
    shadow[a] = d;
    step();
    chk("wr after ack",  wr_ack, 0);
    chk("wr after busy", busy, 0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; miss_req = '0; miss_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; stray = 1'b0;
    for (int i = 0; i < 32768; i++) mem_arr[i] = 16'(i * 2) ^ 16'hA5A5;

    repeat (2) @(posedge clk);
    #2;
    chk_quiet("reset");
    rst_n = 1'b1;
    step();

    // Single miss on ch1
    miss_addr[16 +: 16] = 16'h1236;
    miss_req = 2'b10;
    run_fill(1, 16'h1236, WORDS + LAT - 1, -1);

    // Simultaneous misses from idle pointer
    miss_addr[0 +: 16]  = 16'h2000;
    miss_addr[16 +: 16] = 16'h3008;
    miss_req = 2'b11;
    run_fill(0, 16'h2000, WORDS + LAT - 1, -1);
    run_fill(1, 16'h3008, WORDS + LAT - 1, -1);

    // Write and miss together: write first, fill sees the new word
    wr_addr = 16'h0040; wr_data = 16'hBEEF; wr_req = 1'b1;
    miss_addr[0 +: 16] = 16'h0040;
    miss_req = 2'b01;
    step();
    do_write(16'h0040, 16'hBEEF);
    run_fill(0, 16'h0040, WORDS + LAT - 1, -1);

    // Write raised mid-fill waits for IDLE
    miss_addr[16 +: 16] = 16'h5550;
    miss_req = 2'b10;
    wr_addr = 16'h0100; wr_data = 16'h1234;
    run_fill(1, 16'h5550, WORDS + LAT - 1, 5);
    step();
    do_write(16'h0100, 16'h1234);

    // Miss dropped early: fill still completes
    miss_addr[16 +: 16] = 16'h0A00;
    miss_req = 2'b10;
    run_fill(1, 16'h0A00, 2, -1);

    // Block at top of address space
    miss_addr[0 +: 16] = 16'hFFFE;
    miss_req = 2'b01;
    run_fill(0, 16'hFFFE, WORDS + LAT - 1, -1);

    // ch0 alone, then both: arbitration mode decides the order
    miss_addr[0 +: 16] = 16'h6000;
    miss_req = 2'b01;
    run_fill(0, 16'h6000, WORDS + LAT - 1, -1);
    miss_addr[0 +: 16]  = 16'h6100;
    miss_addr[16 +: 16] = 16'h7000;
    miss_req = 2'b11;
`ifdef MEM_FILL_ARB_RR_EN
    run_fill(1, 16'h7000, WORDS + LAT - 1, -1);
    run_fill(0, 16'h6100, WORDS + LAT - 1, -1);
`else
    run_fill(0, 16'h6100, WORDS + LAT - 1, -1);
    run_fill(1, 16'h7000, WORDS + LAT - 1, -1);
`endif

    // Reset on the third returned word
    miss_addr[0 +: 16] = 16'h0800;
    miss_req = 2'b01;
    for (int k = 0; k <= LAT + 2; k++) step();
    chk("pre-rst fill_we",   fill_we, 2'b01);
    chk("pre-rst fill_addr", fill_addr, 16'h0804);
    rst_n = 1'b0;
    #1;
    chk_quiet("mid-fill rst");
    miss_req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("in rst tag_we %0d", k),  tag_we, 0);
      chk($sformatf("in rst fill_we %0d", k), fill_we, 0);
    end
    rst_n = 1'b1;
    step();
    chk("post-rst busy", busy, 0);
    stray = 1'b1;
    #1;
    chk("stray fill_we",   fill_we, 0);
    chk("stray fill_data", fill_data, 0);
    chk("stray busy",      busy, 0);
    stray = 1'b0;
    step();
    chk("after stray busy", busy, 0);
    chk("after stray grant", grant, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Parametrised successor to the two-cache (I/D) memory front end. One fill engine serves NUM_CH cache miss channels plus one write-through port, all sharing a single pipelined memory.
- Arbitrates between channels, fetches an aligned block word by word, and streams the returned words into the granted cache's data array.
- On the last word it asserts the tag write.
- Sits between the cache arrays and the pipelined main memory model.

Parameters:
- NUM_CH, 2, number of miss channels (ch0 = highest fixed priority).
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- WORDS, 8, words per cache block (power of 2, ≥2).
- BYTES_PER_WORD, 2, address increment per word.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- miss_req  in  NUM_CH  per-channel miss, level, held until that channel's fill_done.
- miss_addr  in  NUM_CH*ADDR_W  per-channel miss byte address; ch i at bits [i*ADDR_W +: ADDR_W].
- grant  out  NUM_CH  one-hot owner of the current fill.
- fill_we  out  NUM_CH  data-array write strobe, granted channel only.
- tag_we  out  NUM_CH  tag write strobe, coincident with the last fill_we.
- fill_done  out  NUM_CH  one-cycle pulse with tag_we.
- fill_addr  out  ADDR_W  byte address of the word being written.
- fill_data  out  DATA_W  word being written (mem_rdata passthrough).
- busy  out  1  state != IDLE.
- wr_req  in  1  write-through request, level, held until wr_ack.
- wr_addr  in  ADDR_W  write-through address.
- wr_data  in  DATA_W  write-through data.
- wr_ack  out  1  one-cycle pulse when the write is issued.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_rvalid  in  1  read data valid. Fixed-latency pipelined memory; one address accepted per cycle.

Behaviour:
- Reset: state IDLE, all counters 0, every output 0. Reset is asynchronous active-low, so a reset mid-fill or mid-write aborts the operation; the memory model is reset by the same signal.
- States:
  - IDLE: wr_req has priority over misses, so a later fill observes the written data. wr_req → WR. Else any miss_req → FILL: grant the winner, latch base = miss_addr with the low log2(WORDS*BYTES_PER_WORD) bits cleared, clear issue_cnt and recv_cnt.
  - WR: for one cycle mem_en=1, mem_wr=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1. Then → IDLE.
  - FILL:
    - While issue_cnt < WORDS: mem_en=1, mem_wr=0, mem_addr = base + issue_cnt*BYTES_PER_WORD, then issue_cnt++.
    - On each mem_rvalid: fill_we[g]=1, fill_addr = base + recv_cnt*BYTES_PER_WORD, fill_data=mem_rdata, then recv_cnt++.
    - When recv_cnt==WORDS-1 and mem_rvalid: tag_we[g]=1 and fill_done[g]=1 that cycle → DONE.
  - DONE: one cycle with grant cleared, so the requester can drop miss_req before re-arbitration. Then → IDLE.
- grant is registered. It is 1 from the first FILL cycle through the last-word cycle and 0 in IDLE, WR and DONE.
- Counters are log2(WORDS)+1 bits wide. Address arithmetic wraps modulo 2^ADDR_W.
- Boundary cases:
  - mem_rvalid outside FILL is ignored.
  - wr_req arriving during FILL waits for IDLE. It is never merged with a fill.
  - miss_req dropped mid-fill: the fill still completes and fill_done still pulses.
  - Simultaneous misses: the lowest index wins; the others wait.
- Fill latency: WORDS + memory latency + 1 cycles from grant to IDLE.

Optional Feature:
- MEM_FILL_ARB_RR_EN defined: round-robin arbitration. The pointer advances to the index after the last granted channel, updated on fill_done.
- Undefined: fixed priority, ch0 highest.
- The write port keeps priority in both modes.

Decomposition:
- Package mem_sys_pkg holds:
  - the state enum (IDLE, WR, FILL, DONE);
  - default width constants;
  - a log2 helper function.
- One sub-module, mem_fill_arb: combinational one-hot select from miss_req, plus the RR pointer register when the macro is defined.

Test Plan:
- Single miss: ch1 miss_addr=0x1236, memory latency 4 → mem_addr 0x1230..0x123E issued on 8 consecutive cycles. fill_we[1] fires 8 times with fill_addr 0x1230..0x123E. tag_we[1] and fill_done[1] fire on the 8th word, then DONE, then IDLE.
- Simultaneous ch0 and ch1 misses, fixed priority → ch0 filled first, ch1 granted in the cycle after DONE. With MEM_FILL_ARB_RR_EN, repeated dual misses alternate ch0, ch1, ch0.
- wr_req (0x0040, 0xBEEF) together with a ch0 miss to 0x0040 → WR first with wr_ack for 1 cycle, then the fill. The fill returns 0xBEEF at fill_addr 0x0040.
- wr_req raised mid-fill → held without wr_ack until the fill completes and the FSM reaches IDLE, then issued for exactly 1 cycle.
- rst_n low on the 3rd returned word → all outputs 0 immediately; no tag_we. A stray mem_rvalid after reset produces no fill_we.
- miss_addr=0xFFFE, WORDS=8 → base 0xFFF0, last fill_addr 0xFFFE, no wrap error.
